// File: rtl/lcd_host_agent_if.sv
// Signal bundle between the host agent and the LCD controller: IROM read port,
// command handshake and IRAM write-back stream.
interface lcd_host_agent_if;
  logic       IROM_rd;
  logic [5:0] IROM_A;
  logic [7:0] IROM_Q;
  // cmd_valid is a one-cycle strobe with cmd stable, raised only while busy=0;
  // the controller accepts by raising busy and frees the slot by lowering it.
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       IRAM_valid;
  logic [5:0] IRAM_A;
  logic [7:0] IRAM_D;
  logic       done;

  modport master (
    input  IROM_rd, IROM_A, busy, IRAM_valid, IRAM_A, IRAM_D, done,
    output IROM_Q, cmd, cmd_valid
  );

  modport slave (
    output IROM_rd, IROM_A, busy, IRAM_valid, IRAM_A, IRAM_D, done,
    input  IROM_Q, cmd, cmd_valid
  );
endinterface

// File: rtl/lcd_host_agent.sv
// Host-side agent for the LCD controller: image ROM server, command FIFO and issuer, IRAM capture.
// Optional feature macro RESULT_CHECK_EN adds a golden store and a mismatch counter.
module lcd_host_agent #(
  parameter int CMDQ_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       img_we,
  input  logic [5:0] img_addr,
  input  logic [7:0] img_data,
  input  logic [3:0] q_cmd,
  input  logic       q_valid,
  output logic       q_ready,
  input  logic       start,
  lcd_host_agent_if.master ctrl,
  input  logic [5:0] res_addr,
  output logic [7:0] res_data,
  output logic [6:0] wr_cnt,
  output logic       finish,
  output logic       error,
`ifdef RESULT_CHECK_EN
  input  logic       gold_we,
  input  logic [5:0] gold_addr,
  input  logic [7:0] gold_data,
  output logic [6:0] mism_cnt,
`endif
  output logic [2:0] state
);
  localparam logic [2:0] S_LOAD   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_ACK    = 3'd2;
  localparam logic [2:0] S_RDY    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam int AW = $clog2(CMDQ_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

  logic [7:0]    img_mem  [64];
  logic [7:0]    res_mem  [64];
  logic [3:0]    fifo_mem [CMDQ_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, push, pop;
  logic [3:0]    fifo_head;
  logic [2:0]    state_q, state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          start_seen, zero_issued, timed, violation;
  logic [3:0]    cmd_q;
  logic          cmd_valid_q;

  assign ctrl.IROM_Q   = ctrl.IROM_rd ? img_mem[ctrl.IROM_A] : 8'd0;
  assign res_data      = res_mem[res_addr];
  assign fifo_empty    = (wr_ptr == rd_ptr);
  assign fifo_full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign q_ready       = !fifo_full;
  assign push          = q_valid && !fifo_full;
  assign fifo_head     = fifo_mem[rd_ptr[AW-1:0]];
  assign ctrl.cmd      = cmd_q;
  assign ctrl.cmd_valid = cmd_valid_q;
  assign state         = state_q;

  // Stores are not reset so an image loaded before reset survives it.
  always_ff @(posedge clk) begin
    if (img_we)          img_mem[img_addr]           <= img_data;
    if (ctrl.IRAM_valid) res_mem[ctrl.IRAM_A]        <= ctrl.IRAM_D;
    if (push)            fifo_mem[wr_ptr[AW-1:0]]    <= q_cmd;
  end

  assign timed = (state_q == S_LOAD) || (state_q == S_ACK) ||
                 (state_q == S_RDY)  || (state_q == S_DRAIN);
  assign violation = (ctrl.IRAM_valid && state_q != S_DRAIN && state_q != S_FINISH) ||
                     (ctrl.done && !zero_issued);

  always_comb begin
    state_nxt = state_q;
    pop       = 1'b0;
    case (state_q)
      S_LOAD:  if (!ctrl.busy && (start_seen || start)) state_nxt = S_ISSUE;
      S_ISSUE: if (!fifo_empty && !ctrl.busy) begin
                 pop       = 1'b1;
                 state_nxt = S_ACK;
               end
      S_ACK:   if (cmd_q == 4'd0)  state_nxt = S_DRAIN;
               else if (ctrl.busy) state_nxt = S_RDY;
      S_RDY:   if (!ctrl.busy) state_nxt = S_ISSUE;
      S_DRAIN: if (ctrl.done)  state_nxt = S_FINISH;
      default: ;
    endcase
    if (state_q != S_FINISH && state_q != S_ERROR && violation) begin
      state_nxt = S_ERROR;
      pop       = 1'b0;
    end else if (timed && state_nxt == state_q && tmo_cnt == TMO_LAST) begin
      state_nxt = S_ERROR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      tmo_cnt     <= '0;
      start_seen  <= 1'b0;
      zero_issued <= 1'b0;
      cmd_q       <= 4'd0;
      cmd_valid_q <= 1'b0;
      finish      <= 1'b0;
      error       <= 1'b0;
      wr_cnt      <= 7'd0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state_q    <= state_nxt;
      tmo_cnt    <= (state_nxt != state_q) ? '0 : (timed ? tmo_cnt + TMO_ONE : tmo_cnt);
      start_seen <= (state_q == S_LOAD) && (state_nxt == S_LOAD) && (start_seen || start);
      cmd_valid_q <= pop;
      if (pop) begin
        cmd_q  <= fifo_head;
        rd_ptr <= rd_ptr + PTR_ONE;
        if (fifo_head == 4'd0) zero_issued <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (state_q == S_DRAIN && state_nxt == S_FINISH) finish <= 1'b1;
      if (state_nxt == S_ERROR) error <= 1'b1;
      if (ctrl.IRAM_valid && wr_cnt != 7'd64) wr_cnt <= wr_cnt + 7'd1;
    end
  end

`ifdef RESULT_CHECK_EN
  logic [7:0] gold_mem [64];

  always_ff @(posedge clk) begin
    if (gold_we) gold_mem[gold_addr] <= gold_data;
  end

  // The compare sees the golden value as it was before any same-cycle gold write.
  always_ff @(posedge clk) begin
    if (reset) mism_cnt <= 7'd0;
    else if (ctrl.IRAM_valid && ctrl.IRAM_D != gold_mem[ctrl.IRAM_A] && mism_cnt != 7'd64)
      mism_cnt <= mism_cnt + 7'd1;
  end
`endif
endmodule

// File: tb/tb_lcd_host_agent.sv
// Bench for lcd_host_agent: a controller emulator drives the agent while a
// transaction-level model predicts every output on each cycle.
`timescale 1ns/1ps
module tb_lcd_host_agent;
  localparam int DEPTH = 8;
  localparam int TMO   = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       img_we;
  logic [5:0] img_addr;
  logic [7:0] img_data;
  logic [3:0] q_cmd;
  logic       q_valid;
  logic       q_ready;
  logic       start;
  logic [5:0] res_addr;
  logic [7:0] res_data;
  logic [6:0] wr_cnt;
  logic       finish;
  logic       error;
  logic [2:0] state;
`ifdef RESULT_CHECK_EN
  logic       gold_we;
  logic [5:0] gold_addr;
  logic [7:0] gold_data;
  logic [6:0] mism_cnt;
`endif

  lcd_host_agent_if bus();

  always #5 clk = ~clk;

  lcd_host_agent #(.CMDQ_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .img_we(img_we), .img_addr(img_addr), .img_data(img_data),
    .q_cmd(q_cmd), .q_valid(q_valid), .q_ready(q_ready), .start(start),
    .ctrl(bus),
    .res_addr(res_addr), .res_data(res_data),
    .wr_cnt(wr_cnt), .finish(finish), .error(error),
`ifdef RESULT_CHECK_EN
    .gold_we(gold_we), .gold_addr(gold_addr), .gold_data(gold_data), .mism_cnt(mism_cnt),
`endif
    .state(state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int W_GO = 0, W_SLOT = 1, W_TAKE = 2, W_FREE = 3, W_DONE = 4, END_OK = 5, END_BAD = 6;
  logic [3:0] exp_q[$];
  logic [7:0] m_img [64];
  logic [7:0] m_res [64];
  bit         m_res_ok [64];
  logic [7:0] m_gold [64];
  int  ph = W_GO, waited = 0, m_wr = 0, m_mism = 0;
  bit  go_seen = 0, zero_sent = 0, m_cv = 0, m_fin = 0, m_err = 0, live = 0;
  logic [3:0] m_cmd = 4'd0;

  task automatic step_model();
    int nxt; bit took; int sz; bit timed;
    if (reset) begin
      exp_q.delete();
      ph = W_GO; waited = 0; go_seen = 0; zero_sent = 0;
      m_cv = 0; m_cmd = 4'd0; m_wr = 0; m_mism = 0; m_fin = 0; m_err = 0;
      live = 1;
    end else begin
      if (bus.IRAM_valid) begin
        if (m_wr < 64) m_wr++;
        if (bus.IRAM_D != m_gold[bus.IRAM_A] && m_mism < 64) m_mism++;
      end
      sz = exp_q.size(); nxt = ph; took = 0;
      if (ph != END_OK && ph != END_BAD &&
          ((bus.IRAM_valid && ph != W_DONE) || (bus.done && !zero_sent)))
        nxt = END_BAD;
      else case (ph)
        W_GO:   if (!bus.busy && (go_seen || start)) nxt = W_SLOT;
        W_SLOT: if (!bus.busy && sz > 0) begin took = 1; nxt = W_TAKE; end
        W_TAKE: nxt = (m_cmd == 4'd0) ? W_DONE : (bus.busy ? W_FREE : W_TAKE);
        W_FREE: if (!bus.busy) nxt = W_SLOT;
        W_DONE: if (bus.done) nxt = END_OK;
        default: ;
      endcase
      timed = (ph == W_GO) || (ph == W_TAKE) || (ph == W_FREE) || (ph == W_DONE);
      if (timed && nxt == ph && waited == TMO - 1) nxt = END_BAD;
      waited  = (nxt != ph) ? 0 : (timed ? waited + 1 : waited);
      go_seen = (ph == W_GO) && (nxt == W_GO) && (go_seen || start);
      m_cv = took;
      if (took) begin
        m_cmd = exp_q.pop_front();
        if (m_cmd == 4'd0) zero_sent = 1;
      end
      if (q_valid && sz < DEPTH) exp_q.push_back(q_cmd);
      if (nxt == END_OK)  m_fin = 1;
      if (nxt == END_BAD) m_err = 1;
      ph = nxt;
    end
    if (bus.IRAM_valid) begin
      m_res[bus.IRAM_A] = bus.IRAM_D;
      m_res_ok[bus.IRAM_A] = 1;
    end
    if (img_we) m_img[img_addr] = img_data;
`ifdef RESULT_CHECK_EN
    if (gold_we) m_gold[gold_addr] = gold_data;
`endif
  endtask

  initial forever begin
    @(posedge clk);
    step_model();
  end

  // Per-cycle comparison, half a cycle after the active edge.
  initial forever begin
    @(negedge clk);
    if (live) begin
      chk("cmd_valid", bus.cmd_valid, m_cv);
      chk("cmd", bus.cmd, m_cmd);
      chk("q_ready", q_ready, exp_q.size() < DEPTH);
      chk("wr_cnt", wr_cnt, m_wr);
      chk("finish", finish, m_fin);
      chk("error", error, m_err);
      chk("IROM_Q", bus.IROM_Q, bus.IROM_rd ? m_img[bus.IROM_A] : 8'd0);
      if (m_res_ok[res_addr]) chk("res_data", res_data, m_res[res_addr]);
`ifdef RESULT_CHECK_EN
      chk("mism_cnt", mism_cnt, m_mism);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_ctrl();
    bus.IROM_rd = 0; bus.IROM_A = '0; bus.busy = 0;
    bus.IRAM_valid = 0; bus.IRAM_A = '0; bus.IRAM_D = '0; bus.done = 0;
    q_valid = 0; start = 0; img_we = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    idle_ctrl();
    repeat (n) tick();
    reset = 0;
  endtask

  // Controller emulation: on each cmd_valid pulse, hold busy for a random spell.
  task automatic serve(input int target, input int budget, output int pulses);
    pulses = 0;
    for (int c = 0; c < budget && pulses < target; c++) begin
      tick();
      if (bus.cmd_valid) begin
        pulses++;
        bus.busy = 1;
        repeat ($urandom_range(1, 4)) tick();
        bus.busy = 0;
      end
    end
  endtask

  logic [7:0] wdata [64];
  logic [3:0] cmds_a [3];

  initial begin
    int pulses, extra, busy_left;
    bit got;
    reset = 1; img_addr = '0; img_data = '0; q_cmd = '0; res_addr = '0;
    idle_ctrl();
`ifdef RESULT_CHECK_EN
    gold_we = 0; gold_addr = '0; gold_data = '0;
`endif
    for (int i = 0; i < 64; i++) wdata[i] = 8'($urandom_range(0, 255));

    // Load image 0..63 (and golden data) while held in reset.
    for (int i = 0; i < 64; i++) begin
      img_we = 1; img_addr = 6'(i); img_data = 8'(i);
`ifdef RESULT_CHECK_EN
      gold_we = 1; gold_addr = 6'(i);
      gold_data = (i == 5 || i == 20 || i == 41) ? (wdata[i] ^ 8'h01) : wdata[i];
`endif
      tick();
    end
    img_we = 0;
`ifdef RESULT_CHECK_EN
    gold_we = 0;
`endif
    chk("rst_cmd_valid", bus.cmd_valid, 1'b0);
    chk("rst_wr_cnt", wr_cnt, 7'd0);
    chk("rst_finish", finish, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_q_ready", q_ready, 1'b1);
    reset = 0;

    // Test A: ROM reads while busy, enqueue {4,7,0}, start, write-back, done.
    cmds_a[0] = 4'd4; cmds_a[1] = 4'd7; cmds_a[2] = 4'd0;
    for (int i = 0; i < 12; i++) begin
      bus.busy = 1; bus.IROM_rd = 1; bus.IROM_A = 6'($urandom_range(0, 63));
      q_valid = (i < 3); q_cmd = (i < 3) ? cmds_a[i] : 4'd0;
      start = (i == 5);
      #1 chk("irom_lit", bus.IROM_Q, {2'b00, bus.IROM_A});
      tick();
    end
    q_valid = 0; start = 0; bus.IROM_rd = 0; bus.busy = 0;
    serve(3, 200, pulses);
    chk("pulses_a", pulses, 3);
    for (int i = 0; i < 64; i++) begin
      bus.IRAM_valid = 1; bus.IRAM_A = 6'(i); bus.IRAM_D = wdata[i];
      tick();
    end
    bus.IRAM_valid = 0; bus.done = 1;
    tick();
    bus.done = 0;
    tick();
    chk("a_finish", finish, 1'b1);
    chk("a_wr_cnt", wr_cnt, 7'd64);
    chk("a_error", error, 1'b0);
    chk("a_cmd_hold", bus.cmd, 4'd0);
`ifdef RESULT_CHECK_EN
    chk("a_mism_cnt", mism_cnt, 7'd3);
`endif
    for (int i = 0; i < 64; i++) begin
      res_addr = 6'(i);
      #1 chk("res_lit", res_data, wdata[i]);
      tick();
    end

    // Test B: nine enqueues into an eight-deep FIFO.
    do_reset(2);
    q_valid = 1;
    for (int i = 0; i < 9; i++) begin
      q_cmd = 4'(i + 1);
      tick();
    end
    q_valid = 0;
    chk("b_q_ready_full", q_ready, 1'b0);
    start = 1;
    tick();
    start = 0;
    serve(9, 120, pulses);
    chk("pulses_b", pulses, 8);
    chk("b_error", error, 1'b0);

    // Test C: busy stuck high after a command -> timeout.
    do_reset(2);
    q_valid = 1; q_cmd = 4'd5;
    tick();
    q_cmd = 4'd6;
    tick();
    q_valid = 0; start = 1;
    tick();
    start = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (bus.cmd_valid) got = 1;
    end
    chk("c_first_pulse", got, 1'b1);
    bus.busy = 1; extra = 0;
    repeat (TMO + 5) begin tick(); if (bus.cmd_valid) extra++; end
    bus.busy = 0;
    repeat (10) begin tick(); if (bus.cmd_valid) extra++; end
    chk("c_error", error, 1'b1);
    chk("c_no_more_pulses", extra, 0);

    // Test D: randomized rounds, each starting with a reset that interrupts the last.
    for (int r = 0; r < 5; r++) begin
      do_reset($urandom_range(1, 3));
      q_valid = 1;
      for (int k = 0; k < $urandom_range(1, 6); k++) begin
        q_cmd = 4'($urandom_range(0, 15));
        tick();
      end
      q_valid = 0; start = 1;
      tick();
      start = 0; busy_left = 0;
      for (int c = 0; c < 150; c++) begin
        tick();
        if (bus.cmd_valid) busy_left = $urandom_range(1, 5);
        bus.busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
        bus.IRAM_valid = ($urandom_range(0, 11) == 0);
        bus.IRAM_A = 6'($urandom_range(0, 63));
        bus.IRAM_D = 8'($urandom_range(0, 255));
        bus.done = ($urandom_range(0, 49) == 0);
        q_valid = ($urandom_range(0, 7) == 0);
        q_cmd = 4'($urandom_range(0, 15));
        start = ($urandom_range(0, 29) == 0);
        bus.IROM_rd = 1'($urandom_range(0, 1));
        bus.IROM_A = 6'($urandom_range(0, 63));
        res_addr = 6'($urandom_range(0, 63));
        img_we = ($urandom_range(0, 15) == 0);
        img_addr = 6'($urandom_range(0, 63));
        img_data = 8'($urandom_range(0, 255));
      end
      idle_ctrl();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
